ram2p_be: RTL and testbench

//  Single-clock true dual-port RAM with per-byte write enables, selectable read-during-write

---
 rtl/ram2p_be_if.sv | 36 +++
 rtl/ram2p_be.sv | 167 ++++++++++++++++
 tb/tb_ram2p_be.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram2p_be_if.sv
// Dual-port access bundle for ram2p_be: per-port enable, write, byte enables, address,
// write data, and returned read data with its valid pulse.
interface ram2p_be_if #(
  parameter int unsigned AWID = 8,
  parameter int unsigned DWID = 16
);
  localparam int unsigned BEW = DWID / 8;

  logic            i_ena;
  logic            i_wea;
  logic [BEW-1:0]  i_bea;
  logic [AWID-1:0] i_addra;
  logic [DWID-1:0] i_data;
  logic [DWID-1:0] o_data;
  logic            o_vlda;

  logic            i_enb;
  logic            i_web;
  logic [BEW-1:0]  i_beb;
  logic [AWID-1:0] i_addrb;
  logic [DWID-1:0] i_datb;
  logic [DWID-1:0] o_datb;
  logic            o_vldb;

  modport slave (
    input  i_ena, i_wea, i_bea, i_addra, i_data,
    input  i_enb, i_web, i_beb, i_addrb, i_datb,
    output o_data, o_vlda, o_datb, o_vldb
  );

  modport master (
    output i_ena, i_wea, i_bea, i_addra, i_data,
    output i_enb, i_web, i_beb, i_addrb, i_datb,
    input  o_data, o_vlda, o_datb, o_vldb
  );
endinterface

// File: rtl/ram2p_be.sv
// Single-clock true dual-port RAM with byte enables, selectable read-during-write behaviour,
// optional output register, a clear engine that fills INIT_VAL, and a collision flag.
module ram2p_be #(
  parameter int unsigned   AWID       = 8,
  parameter int unsigned   DEPTH      = 256,
  parameter int unsigned   DWID       = 16,
  parameter int unsigned   RDW_MODE   = 0,
  parameter int unsigned   OUT_REG    = 0,
  parameter logic [DWID-1:0] INIT_VAL = '0,
  parameter bit            CLR_ON_RST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  ram2p_be_if.slave      bus,
  input  logic           i_clr,
  output logic           o_ready,
  output logic           o_collision
);

  localparam int unsigned BEW = DWID / 8;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e          state_q, state_d;
  logic [AWID-1:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            clr_we;

  logic [DWID-1:0] mem_q [DEPTH];

  logic            acc_a, acc_b;
  logic            inr_a, inr_b;
  logic [BEW-1:0]  wbe_a, wbe_b;
  logic            collide;
  logic [DWID-1:0] rd_old_a, rd_old_b;
  logic [DWID-1:0] rd_a, rd_b;

  logic            vld1_a_q, vld1_b_q;
  logic [DWID-1:0] dat1_a_q, dat1_b_q;
  logic            col_q;

  // Replace the bytes selected by mask with the corresponding write-data bytes.
  function automatic logic [DWID-1:0] merge_bytes(input logic [DWID-1:0] old_w,
                                                  input logic [DWID-1:0] new_w,
                                                  input logic [BEW-1:0]  mask);
    logic [DWID-1:0] res;
    res = old_w;
    for (int k = 0; k < int'(BEW); k++) begin
      if (mask[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  // Clear-sweep / ready state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_ON_RST ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
      ready_q <= !CLR_ON_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == AWID'(DEPTH - 1)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AWID'(1);
        end
      end
      ST_READY: begin
        if (i_clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
    ready_d = (state_d == ST_READY);
  end

  assign inr_a = 32'(bus.i_addra) < DEPTH;
  assign inr_b = 32'(bus.i_addrb) < DEPTH;
  assign acc_a = ready_q & bus.i_ena;
  assign acc_b = ready_q & bus.i_enb;
  assign wbe_a = {BEW{acc_a & inr_a & bus.i_wea}} & bus.i_bea;
  assign wbe_b = {BEW{acc_b & inr_b & bus.i_web}} & bus.i_beb;

  // A real collision needs a byte actually being written; an all-zero BE write is a read.
  assign collide = acc_a & acc_b & inr_a & (bus.i_addra == bus.i_addrb) &
                   ((bus.i_wea & (|bus.i_bea)) | (bus.i_web & (|bus.i_beb)));

  // Port A is applied last so it wins any byte both ports enable.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[cnt_q] <= INIT_VAL;
    for (int k = 0; k < int'(BEW); k++) begin
      if (wbe_b[k]) mem_q[bus.i_addrb][8*k +: 8] <= bus.i_datb[8*k +: 8];
      if (wbe_a[k]) mem_q[bus.i_addra][8*k +: 8] <= bus.i_data[8*k +: 8];
    end
  end

  // Each port only ever sees its own write merged; the other port's write is invisible.
  assign rd_old_a = inr_a ? mem_q[bus.i_addra] : '0;
  assign rd_old_b = inr_b ? mem_q[bus.i_addrb] : '0;
  assign rd_a     = (RDW_MODE != 0) ? merge_bytes(rd_old_a, bus.i_data, wbe_a) : rd_old_a;
  assign rd_b     = (RDW_MODE != 0) ? merge_bytes(rd_old_b, bus.i_datb, wbe_b) : rd_old_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_a_q <= 1'b0;
      vld1_b_q <= 1'b0;
      dat1_a_q <= '0;
      dat1_b_q <= '0;
      col_q    <= 1'b0;
    end else begin
      vld1_a_q <= acc_a;
      vld1_b_q <= acc_b;
      if (acc_a) dat1_a_q <= rd_a;
      if (acc_b) dat1_b_q <= rd_b;
      col_q    <= collide;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic            vld2_a_q, vld2_b_q;
      logic [DWID-1:0] dat2_a_q, dat2_b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld2_a_q <= 1'b0;
          vld2_b_q <= 1'b0;
          dat2_a_q <= '0;
          dat2_b_q <= '0;
        end else begin
          vld2_a_q <= vld1_a_q;
          vld2_b_q <= vld1_b_q;
          if (vld1_a_q) dat2_a_q <= dat1_a_q;
          if (vld1_b_q) dat2_b_q <= dat1_b_q;
        end
      end

      assign bus.o_vlda = vld2_a_q;
      assign bus.o_vldb = vld2_b_q;
      assign bus.o_data = dat2_a_q;
      assign bus.o_datb = dat2_b_q;
    end else begin : g_noreg
      assign bus.o_vlda = vld1_a_q;
      assign bus.o_vldb = vld1_b_q;
      assign bus.o_data = dat1_a_q;
      assign bus.o_datb = dat1_b_q;
    end
  endgenerate

  assign o_ready     = ready_q;
  assign o_collision = col_q;

endmodule

// File: tb/tb_ram2p_be.sv
// Bench for ram2p_be: two configurations driven in lockstep (256 words/old-data/no output
// register/INIT A5A5, and 200 words/new-data/output register/INIT 0) against a word-level model.
module tb_ram2p_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        ena = 1'b0, wea = 1'b0, enb = 1'b0, web = 1'b0;
  logic [1:0]  bea = '0, beb = '0;
  logic [7:0]  addra = '0, addrb = '0;
  logic [15:0] data = '0, datb = '0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram2p_be_if #(.AWID(8), .DWID(16)) bus0 ();
  ram2p_be_if #(.AWID(8), .DWID(16)) bus1 ();

  assign bus0.i_ena = ena;   assign bus0.i_wea = wea;   assign bus0.i_bea = bea;
  assign bus0.i_addra = addra; assign bus0.i_data = data;
  assign bus0.i_enb = enb;   assign bus0.i_web = web;   assign bus0.i_beb = beb;
  assign bus0.i_addrb = addrb; assign bus0.i_datb = datb;
  assign bus1.i_ena = ena;   assign bus1.i_wea = wea;   assign bus1.i_bea = bea;
  assign bus1.i_addra = addra; assign bus1.i_data = data;
  assign bus1.i_enb = enb;   assign bus1.i_web = web;   assign bus1.i_beb = beb;
  assign bus1.i_addrb = addrb; assign bus1.i_datb = datb;

  logic rdy0, rdy1, col0, col1;

  ram2p_be #(.AWID(8), .DEPTH(256), .DWID(16), .RDW_MODE(0), .OUT_REG(0),
             .INIT_VAL(16'hA5A5), .CLR_ON_RST(1'b1)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .i_clr(clr), .o_ready(rdy0), .o_collision(col0));

  ram2p_be #(.AWID(8), .DEPTH(200), .DWID(16), .RDW_MODE(1), .OUT_REG(1),
             .INIT_VAL(16'h0000), .CLR_ON_RST(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .i_clr(clr), .o_ready(rdy1), .o_collision(col1));

  logic [15:0] o_da [2];
  logic [15:0] o_db [2];
  logic        o_va [2];
  logic        o_vb [2];
  logic        o_rdy [2];
  logic        o_col [2];

  assign o_da[0] = bus0.o_data;  assign o_db[0] = bus0.o_datb;
  assign o_va[0] = bus0.o_vlda;  assign o_vb[0] = bus0.o_vldb;
  assign o_da[1] = bus1.o_data;  assign o_db[1] = bus1.o_datb;
  assign o_va[1] = bus1.o_vlda;  assign o_vb[1] = bus1.o_vldb;
  assign o_rdy[0] = rdy0;        assign o_rdy[1] = rdy1;
  assign o_col[0] = col0;        assign o_col[1] = col1;

  // Reference model: word array per instance, ready flag with sweep count, read latency.
  int          depth [2] = '{256, 200};
  bit          rdw   [2] = '{1'b0, 1'b1};
  int          lat   [2] = '{1, 2};
  logic [15:0] init_v [2] = '{16'hA5A5, 16'h0000};
  logic [15:0] mmem [2][256];
  bit          m_rdy [2];
  int          m_cnt [2];
  logic        e_va [2], e_vb [2], e_col [2];
  logic [15:0] e_da [2], e_db [2];
  logic        p_va [2], p_vb [2];
  logic [15:0] p_da [2], p_db [2];

  function automatic logic [15:0] port_read(int k, logic [7:0] a, logic we,
                                            logic [1:0] be, logic [15:0] d);
    logic [15:0] w;
    if (int'(a) >= depth[k]) return 16'h0000;
    w = mmem[k][a];
    if (rdw[k] && we)
      for (int j = 0; j < 2; j++) if (be[j]) w[8*j +: 8] = d[8*j +: 8];
    return w;
  endfunction

  task automatic model_step();
    logic        acc_a, acc_b, col;
    logic [15:0] rd_a, rd_b;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_rdy[k] = 1'b0; m_cnt[k] = 0;
        e_va[k] = 1'b0; e_vb[k] = 1'b0; e_da[k] = '0; e_db[k] = '0; e_col[k] = 1'b0;
        p_va[k] = 1'b0; p_vb[k] = 1'b0; p_da[k] = '0; p_db[k] = '0;
      end else begin
        acc_a = m_rdy[k] && ena;
        acc_b = m_rdy[k] && enb;
        rd_a  = port_read(k, addra, wea, bea, data);
        rd_b  = port_read(k, addrb, web, beb, datb);
        col   = acc_a && acc_b && (addra == addrb) && (int'(addra) < depth[k]) &&
                ((wea && bea != 2'b00) || (web && beb != 2'b00));
        if (acc_b && web && int'(addrb) < depth[k])
          for (int j = 0; j < 2; j++) if (beb[j]) mmem[k][addrb][8*j +: 8] = datb[8*j +: 8];
        if (acc_a && wea && int'(addra) < depth[k])
          for (int j = 0; j < 2; j++) if (bea[j]) mmem[k][addra][8*j +: 8] = data[8*j +: 8];
        if (!m_rdy[k]) begin
          mmem[k][m_cnt[k]] = init_v[k];
          if (m_cnt[k] == depth[k] - 1) begin m_rdy[k] = 1'b1; m_cnt[k] = 0; end
          else m_cnt[k]++;
        end else if (clr) begin
          m_rdy[k] = 1'b0; m_cnt[k] = 0;
        end
        e_col[k] = col;
        if (lat[k] == 1) begin
          e_va[k] = acc_a; if (acc_a) e_da[k] = rd_a;
          e_vb[k] = acc_b; if (acc_b) e_db[k] = rd_b;
        end else begin
          e_va[k] = p_va[k]; if (p_va[k]) e_da[k] = p_da[k];
          e_vb[k] = p_vb[k]; if (p_vb[k]) e_db[k] = p_db[k];
          p_va[k] = acc_a;   if (acc_a) p_da[k] = rd_a;
          p_vb[k] = acc_b;   if (acc_b) p_db[k] = rd_b;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0; bea = '0; enb = 1'b0; web = 1'b0; beb = '0; clr = 1'b0;
  endtask

  task automatic test_reset();
    int zc [2];
    rst = 1'b1; idle(); tick();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (o_rdy[k] !== 1'b0) begin
        n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, o_rdy[k]);
      end
      n_chk++;
      if ({o_va[k], o_vb[k], o_col[k], o_da[k], o_db[k]} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got va=%b vb=%b col=%b da=%h db=%h expected all 0",
                 k, o_va[k], o_vb[k], o_col[k], o_da[k], o_db[k]);
      end
    end
    rst = 1'b0;
    zc = '{0, 0};
    for (int i = 0; i < 400 && !(o_rdy[0] && o_rdy[1]); i++) begin
      for (int k = 0; k < 2; k++) if (!o_rdy[k]) zc[k]++;
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (zc[k] != depth[k]) begin
        n_fail++; $display("FAIL reset_sweep_len[%0d]: got %0d cycles expected %0d", k, zc[k], depth[k]);
      end
    end
  endtask

  task automatic test_init_read();
    logic [7:0] addrs [3] = '{8'd0, 8'd128, 8'd255};
    for (int i = 0; i < 3; i++) begin
      idle(); ena = 1'b1; addra = addrs[i]; tick(); idle();
      n_chk++;
      if ({o_va[0], o_da[0]} !== {1'b1, 16'hA5A5}) begin
        n_fail++; $display("FAIL init_read_u0 @%0d: got vld=%b data=%h expected 1/a5a5", addrs[i], o_va[0], o_da[0]);
      end
      n_chk++;
      if (o_va[1] !== 1'b0) begin
        n_fail++; $display("FAIL init_early_vld_u1 @%0d: got %b expected 0", addrs[i], o_va[1]);
      end
      tick();
      n_chk++;
      if ({o_va[1], o_da[1]} !== {1'b1, 16'h0000}) begin
        n_fail++; $display("FAIL init_read_u1 @%0d: got vld=%b data=%h expected 1/0000", addrs[i], o_va[1], o_da[1]);
      end
      n_chk++;
      if (o_va[0] !== 1'b0) begin
        n_fail++; $display("FAIL init_vld_pulse_u0 @%0d: got %b expected 0", addrs[i], o_va[0]);
      end
    end
  endtask

  task automatic test_byte_write();
    idle(); ena = 1'b1; wea = 1'b1; bea = 2'b11; addra = 8'h10; data = 16'h1234; tick();
    bea = 2'b01; data = 16'hFFFF; tick();
    wea = 1'b0; bea = 2'b00; tick(); idle();
    n_chk++;
    if ({o_va[0], o_da[0]} !== {1'b1, 16'h12FF}) begin
      n_fail++; $display("FAIL byte_write_u0: got vld=%b data=%h expected 1/12ff", o_va[0], o_da[0]);
    end
    tick();
    n_chk++;
    if ({o_va[1], o_da[1], o_va[0]} !== {1'b1, 16'h12FF, 1'b0}) begin
      n_fail++; $display("FAIL byte_write_u1: got vld=%b data=%h u0vld=%b expected 1/12ff/0", o_va[1], o_da[1], o_va[0]);
    end
    tick();
    n_chk++;
    if (o_va[1] !== 1'b0) begin
      n_fail++; $display("FAIL byte_write_u1_pulse: got %b expected 0", o_va[1]);
    end
  endtask

  task automatic test_rdw();
    idle(); ena = 1'b1; wea = 1'b1; bea = 2'b11; addra = 8'h20; data = 16'h0000; tick();
    data = 16'hBEEF; tick(); idle();
    n_chk++;
    if (o_da[0] !== 16'h0000) begin
      n_fail++; $display("FAIL rdw_old_u0: got %h expected 0000", o_da[0]);
    end
    tick();
    n_chk++;
    if (o_da[1] !== 16'hBEEF) begin
      n_fail++; $display("FAIL rdw_new_u1: got %h expected beef", o_da[1]);
    end
  endtask

  task automatic test_collision();
    idle();
    ena = 1'b1; wea = 1'b1; bea = 2'b10; addra = 8'h30; data = 16'h1111;
    enb = 1'b1; web = 1'b1; beb = 2'b11; addrb = 8'h30; datb = 16'h2222;
    tick(); idle();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (o_col[k] !== 1'b1) begin n_fail++; $display("FAIL coll_ww[%0d]: got %b expected 1", k, o_col[k]); end
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (o_col[k] !== 1'b0) begin n_fail++; $display("FAIL coll_pulse[%0d]: got %b expected 0", k, o_col[k]); end
    end
    ena = 1'b1; addra = 8'h30; tick(); idle();
    n_chk++;
    if (o_da[0] !== 16'h1122) begin n_fail++; $display("FAIL coll_merge_u0: got %h expected 1122", o_da[0]); end
    tick();
    n_chk++;
    if (o_da[1] !== 16'h1122) begin n_fail++; $display("FAIL coll_merge_u1: got %h expected 1122", o_da[1]); end
    ena = 1'b1; wea = 1'b1; bea = 2'b11; addra = 8'h30; data = 16'h3333;
    enb = 1'b1; web = 1'b0; addrb = 8'h30;
    tick(); idle();
    n_chk++;
    if ({o_col[0], o_col[1], o_db[0]} !== {1'b1, 1'b1, 16'h1122}) begin
      n_fail++; $display("FAIL coll_wr: got col=%b%b datb_u0=%h expected 11/1122", o_col[0], o_col[1], o_db[0]);
    end
    tick();
    n_chk++;
    if ({o_col[0], o_col[1], o_db[1]} !== {1'b0, 1'b0, 16'h1122}) begin
      n_fail++; $display("FAIL coll_wr_u1: got col=%b%b datb_u1=%h expected 00/1122", o_col[0], o_col[1], o_db[1]);
    end
  endtask

  task automatic test_clear_rst();
    int          zc [2];
    int          vld_seen;
    logic [7:0]  addrs [6] = '{8'd0, 8'd5, 8'h10, 8'h30, 8'd99, 8'd199};
    idle(); clr = 1'b1; tick(); clr = 1'b0;
    n_chk++;
    if ({o_rdy[0], o_rdy[1]} !== 2'b00) begin
      n_fail++; $display("FAIL clr_enter: got ready=%b%b expected 00", o_rdy[0], o_rdy[1]);
    end
    vld_seen = 0;
    ena = 1'b1; wea = 1'b1; bea = 2'b11; addra = 8'd5; data = 16'h7777;
    for (int i = 0; i < 100; i++) begin
      clr = (i == 50);
      tick();
      if (o_va[0] || o_va[1]) vld_seen++;
    end
    clr = 1'b0;
    n_chk++;
    if (vld_seen != 0 || o_rdy[0] !== 1'b0) begin
      n_fail++; $display("FAIL clr_drop: got %0d valid pulses ready=%b expected 0/0", vld_seen, o_rdy[0]);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    zc = '{0, 0};
    for (int i = 0; i < 400 && !(o_rdy[0] && o_rdy[1]); i++) begin
      ena = !(o_rdy[0] || o_rdy[1]);
      for (int k = 0; k < 2; k++) if (!o_rdy[k]) zc[k]++;
      tick();
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (zc[k] != depth[k]) begin
        n_fail++; $display("FAIL clr_restart_len[%0d]: got %0d cycles expected %0d", k, zc[k], depth[k]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      ena = 1'b1; addra = addrs[i]; tick(); idle();
      n_chk++;
      if (o_da[0] !== 16'hA5A5) begin n_fail++; $display("FAIL clr_content_u0 @%0d: got %h expected a5a5", addrs[i], o_da[0]); end
      tick();
      n_chk++;
      if (o_da[1] !== 16'h0000) begin n_fail++; $display("FAIL clr_content_u1 @%0d: got %h expected 0000", addrs[i], o_da[1]); end
    end
  endtask

  task automatic test_out_of_range();
    idle(); ena = 1'b1; wea = 1'b1; bea = 2'b11; addra = 8'd250; data = 16'h5A5A; tick();
    wea = 1'b0; bea = 2'b00; tick(); idle();
    n_chk++;
    if ({o_va[0], o_da[0]} !== {1'b1, 16'h5A5A}) begin
      n_fail++; $display("FAIL oor_inrange_u0: got vld=%b data=%h expected 1/5a5a", o_va[0], o_da[0]);
    end
    tick();
    n_chk++;
    if ({o_va[1], o_da[1]} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL oor_read_u1: got vld=%b data=%h expected 1/0000", o_va[1], o_da[1]);
    end
    ena = 1'b1; addra = 8'd50; tick(); idle(); tick();
    n_chk++;
    if ({o_va[1], o_da[1]} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL oor_alias_u1: got vld=%b data=%h expected 1/0000", o_va[1], o_da[1]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      ena   = 1'($urandom_range(0, 1));
      enb   = 1'($urandom_range(0, 1));
      wea   = 1'($urandom_range(0, 1));
      web   = 1'($urandom_range(0, 1));
      bea   = 2'($urandom);
      beb   = 2'($urandom);
      addra = ($urandom_range(0, 3) == 0) ? 8'h30 : 8'($urandom);
      addrb = ($urandom_range(0, 3) == 0) ? 8'h30 : 8'($urandom);
      data  = 16'($urandom);
      datb  = 16'($urandom);
      clr   = ($urandom_range(0, 299) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        n_chk++;
        if (o_rdy[k] !== m_rdy[k]) begin
          n_fail++; $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", k, i, o_rdy[k], m_rdy[k]);
        end
        n_chk++;
        if (o_col[k] !== e_col[k]) begin
          n_fail++; $display("FAIL rand_coll[%0d] cyc %0d: got %b expected %b", k, i, o_col[k], e_col[k]);
        end
        n_chk++;
        if (o_va[k] !== e_va[k]) begin
          n_fail++; $display("FAIL rand_vlda[%0d] cyc %0d: got %b expected %b", k, i, o_va[k], e_va[k]);
        end
        n_chk++;
        if (o_vb[k] !== e_vb[k]) begin
          n_fail++; $display("FAIL rand_vldb[%0d] cyc %0d: got %b expected %b", k, i, o_vb[k], e_vb[k]);
        end
        n_chk++;
        if (o_da[k] !== e_da[k]) begin
          n_fail++; $display("FAIL rand_data[%0d] cyc %0d: got %h expected %h", k, i, o_da[k], e_da[k]);
        end
        n_chk++;
        if (o_db[k] !== e_db[k]) begin
          n_fail++; $display("FAIL rand_datb[%0d] cyc %0d: got %h expected %h", k, i, o_db[k], e_db[k]);
        end
      end
    end
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_init_read();
    test_byte_write();
    test_rdw();
    test_collision();
    test_clear_rst();
    test_out_of_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
